nfc_reg_seq: RTL and testbench

- Hardware register sequencer placed directly upstream of the nfc controller. It drives the nfc CPU register port (mif_nfc_reg_addr/rd/wr/din) and reads back nfc_mif_reg_dout.
- One request programs a complete NAND operation in a fixed order: row/column address bytes, address-cycle count, timing, transfer count, then the IF_CTRL0 kick. It then polls the nfc status register until the done bit is set or a timeout expires.
- This removes per-operation CPU register traffic for page read and program.

---
 rtl/nfc_reg_seq_pkg.sv | 42 ++++
 rtl/nfc_reg_seq.sv | 204 ++++++++++++++++++++
 tb/tb_nfc_reg_seq.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nfc_reg_seq_pkg.sv
// Shared constants and types for the nfc register sequencer: nfc register
// offsets, the done-bit position, the FSM state encoding and the latched request.
package nfc_reg_seq_pkg;

    localparam logic [8:0] NFC_IF_CTRL0_OFFSET     = 9'h020;
    localparam logic [8:0] NFC_IF_STATUS_OFFSET    = 9'h021;
    localparam logic [8:0] NFC_ROW_ADDR0_OFFSET    = 9'h010;
    localparam logic [8:0] NFC_COLUMN_ADDR0_OFFSET = 9'h014;
    localparam logic [8:0] NFC_ADDR_CNT_OFFSET     = 9'h018;
    localparam logic [8:0] NFC_TIMING_CONFC_OFFSET = 9'h019;
    localparam logic [8:0] NFC_TRN_CNT0_OFFSET     = 9'h01a;

    localparam int NFC_STATUS_DONE_BIT = 0;

    // Write list runs from index 0 to 12; index 12 is the IF_CTRL0 kick.
    localparam logic [3:0] LAST_WR_IDX = 4'd12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_GAP,
        ST_RD,
        ST_WAIT,
        ST_CHK,
        ST_POLLGAP,
        ST_DONE
    } seq_state_e;

    typedef struct packed {
        logic [31:0] row_addr;
        logic [31:0] col_addr;
        logic [7:0]  addr_cnt;
        logic [7:0]  timing;
        logic [15:0] trn_cnt;
        logic [7:0]  ctrl;
    } seq_cmd_t;

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] sel);
        return word[{sel, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/nfc_reg_seq.sv
// Register sequencer in front of the nfc CPU register port: writes the full
// operation setup, kicks IF_CTRL0, then polls the status register for done.
module nfc_reg_seq
    import nfc_reg_seq_pkg::*;
#(
    parameter logic [8:0]  ROW_ADDR0_OFS = NFC_ROW_ADDR0_OFFSET,
    parameter logic [8:0]  COL_ADDR0_OFS = NFC_COLUMN_ADDR0_OFFSET,
    parameter logic [8:0]  ADDR_CNT_OFS  = NFC_ADDR_CNT_OFFSET,
    parameter logic [8:0]  TIMING_OFS    = NFC_TIMING_CONFC_OFFSET,
    parameter logic [8:0]  TRN_CNT0_OFS  = NFC_TRN_CNT0_OFFSET,
    parameter logic [8:0]  CTRL0_OFS     = NFC_IF_CTRL0_OFFSET,
    parameter logic [8:0]  STATUS_OFS    = NFC_IF_STATUS_OFFSET,
    parameter int          DONE_BIT      = NFC_STATUS_DONE_BIT,
    parameter int          RD_LAT        = 1,
    parameter int          POLL_GAP      = 8,
    parameter logic [15:0] POLL_MAX      = 16'd4096
) (
    input  logic        nfc_clk,
    input  logic        rstb_nfc,
    input  logic        seq_req,
    output logic        seq_ack,
    output logic        seq_busy,
    input  logic [31:0] seq_row_addr,
    input  logic [31:0] seq_col_addr,
    input  logic [7:0]  seq_addr_cnt,
    input  logic [7:0]  seq_timing,
    input  logic [15:0] seq_trn_cnt,
    input  logic [7:0]  seq_ctrl,
    output logic        seq_done,
    output logic        seq_timeout,
    output logic [8:0]  reg_addr,
    output logic        reg_rd,
    output logic        reg_wr,
    output logic [7:0]  reg_din,
    input  logic [7:0]  reg_dout
);

    localparam logic [2:0] DONE_IDX  = 3'(DONE_BIT);
    localparam logic [3:0] WAIT_LAST = 4'(RD_LAT - 2);
    localparam logic [3:0] GAP_LAST  = 4'(POLL_GAP - 1);

    seq_state_e  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  gap_q, gap_d;
    logic [15:0] poll_q, poll_d;
    logic        timeout_q, timeout_d;
    seq_cmd_t    cmd_q, cmd_d;

    logic [8:0]  wr_addr;
    logic [7:0]  wr_data;

    always_ff @(posedge nfc_clk or negedge rstb_nfc) begin
        if (!rstb_nfc) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            gap_q     <= '0;
            poll_q    <= '0;
            timeout_q <= 1'b0;
            cmd_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            poll_q    <= poll_d;
            timeout_q <= timeout_d;
            cmd_q     <= cmd_d;
        end
    end

    // Write-list mux: register address and data for the current write index.
    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        case (idx_q)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                wr_addr = ROW_ADDR0_OFS + 9'(idx_q[1:0]);
                wr_data = byte_sel(cmd_q.row_addr, idx_q[1:0]);
            end
            4'd4, 4'd5, 4'd6, 4'd7: begin
                wr_addr = COL_ADDR0_OFS + 9'(idx_q[1:0]);
                wr_data = byte_sel(cmd_q.col_addr, idx_q[1:0]);
            end
            4'd8: begin
                wr_addr = ADDR_CNT_OFS;
                wr_data = cmd_q.addr_cnt;
            end
            4'd9: begin
                wr_addr = TIMING_OFS;
                wr_data = cmd_q.timing;
            end
            4'd10: begin
                wr_addr = TRN_CNT0_OFS;
                wr_data = cmd_q.trn_cnt[7:0];
            end
            4'd11: begin
                wr_addr = TRN_CNT0_OFS + 9'd1;
                wr_data = cmd_q.trn_cnt[15:8];
            end
            4'd12: begin
                wr_addr = CTRL0_OFS;
                wr_data = cmd_q.ctrl;
            end
            default: begin
                wr_addr = '0;
                wr_data = '0;
            end
        endcase
    end

    // The accept path is gated by reset so every output is quiet while reset is held.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        poll_d      = poll_q;
        timeout_d   = timeout_q;
        cmd_d       = cmd_q;
        seq_ack     = 1'b0;
        seq_busy    = 1'b0;
        seq_done    = 1'b0;
        seq_timeout = 1'b0;
        reg_wr      = 1'b0;
        reg_rd      = 1'b0;
        reg_addr    = '0;
        reg_din     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (seq_req && rstb_nfc) begin
                    seq_ack  = 1'b1;
                    seq_busy = 1'b1;
                    cmd_d    = '{row_addr: seq_row_addr, col_addr: seq_col_addr,
                                 addr_cnt: seq_addr_cnt, timing: seq_timing,
                                 trn_cnt: seq_trn_cnt, ctrl: seq_ctrl};
                    idx_d    = '0;
                    state_d  = ST_WR;
                end
            end
            ST_WR: begin
                seq_busy = 1'b1;
                reg_wr   = 1'b1;
                reg_addr = wr_addr;
                reg_din  = wr_data;
                state_d  = ST_GAP;
            end
            ST_GAP: begin
                seq_busy = 1'b1;
                if (idx_q == LAST_WR_IDX) begin
                    poll_d  = '0;
                    state_d = ST_RD;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_WR;
                end
            end
            ST_RD: begin
                seq_busy = 1'b1;
                reg_rd   = 1'b1;
                reg_addr = STATUS_OFS;
                gap_d    = '0;
                state_d  = (RD_LAT > 1) ? ST_WAIT : ST_CHK;
            end
            ST_WAIT: begin
                seq_busy = 1'b1;
                if (gap_q == WAIT_LAST) begin
                    state_d = ST_CHK;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            ST_CHK: begin
                seq_busy = 1'b1;
                if (reg_dout[DONE_IDX]) begin
                    timeout_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (poll_q == POLL_MAX - 16'd1) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    poll_d  = poll_q + 16'd1;
                    gap_d   = '0;
                    state_d = (POLL_GAP > 0) ? ST_POLLGAP : ST_RD;
                end
            end
            ST_POLLGAP: begin
                seq_busy = 1'b1;
                if (gap_q == GAP_LAST) begin
                    state_d = ST_RD;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            ST_DONE: begin
                seq_done    = 1'b1;
                seq_timeout = timeout_q;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nfc_reg_seq.sv
// Bench for nfc_reg_seq: a timeline model of the expected bus trace checked every
// cycle, plus literal expectations for write order, poll spacing and completion.
module tb_nfc_reg_seq;
    import nfc_reg_seq_pkg::*;

    localparam int RD_LAT_A   = 3;
    localparam int POLL_GAP_A = 8;
    localparam int POLL_MAX_A = 4;
    localparam int PERIOD_A   = POLL_GAP_A + RD_LAT_A + 1;
    localparam int KICK_K     = 25;
    localparam int FIRST_RD_K = 27;

    logic        nfc_clk = 1'b0;
    logic        rstb_nfc = 1'b0;
    logic        seq_req = 1'b0;
    logic        seq_req_b = 1'b0;
    logic [31:0] row = '0;
    logic [31:0] col = '0;
    logic [7:0]  addr_cnt = '0;
    logic [7:0]  timing = '0;
    logic [15:0] trn = '0;
    logic [7:0]  ctrl = '0;

    logic       a_ack, a_busy, a_done, a_to, a_wr, a_rd;
    logic [8:0] a_addr;
    logic [7:0] a_din, a_dout;
    logic       b_ack, b_busy, b_done, b_to, b_wr, b_rd;
    logic [8:0] b_addr;
    logic [7:0] b_din, b_dout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stub_done_poll = 0;

    always #5 nfc_clk = ~nfc_clk;
    always @(posedge nfc_clk) cyc <= cyc + 1;

    nfc_reg_seq #(.RD_LAT(RD_LAT_A), .POLL_GAP(POLL_GAP_A), .POLL_MAX(16'(POLL_MAX_A))) dut (
        .nfc_clk(nfc_clk), .rstb_nfc(rstb_nfc), .seq_req(seq_req), .seq_ack(a_ack),
        .seq_busy(a_busy), .seq_row_addr(row), .seq_col_addr(col), .seq_addr_cnt(addr_cnt),
        .seq_timing(timing), .seq_trn_cnt(trn), .seq_ctrl(ctrl), .seq_done(a_done),
        .seq_timeout(a_to), .reg_addr(a_addr), .reg_rd(a_rd), .reg_wr(a_wr),
        .reg_din(a_din), .reg_dout(a_dout)
    );

    nfc_reg_seq #(.RD_LAT(1), .POLL_GAP(8), .POLL_MAX(16'd4)) dut_lat1 (
        .nfc_clk(nfc_clk), .rstb_nfc(rstb_nfc), .seq_req(seq_req_b), .seq_ack(b_ack),
        .seq_busy(b_busy), .seq_row_addr(row), .seq_col_addr(col), .seq_addr_cnt(addr_cnt),
        .seq_timing(timing), .seq_trn_cnt(trn), .seq_ctrl(ctrl), .seq_done(b_done),
        .seq_timeout(b_to), .reg_addr(b_addr), .reg_rd(b_rd), .reg_wr(b_wr),
        .reg_din(b_din), .reg_dout(b_dout)
    );

    // Status stubs: done bit appears only exactly 3 cycles after a read, from poll N on.
    int a_rd_cnt = 0, a_last_rd = -100, b_rd_cnt = 0, b_last_rd = -100;
    always @(posedge nfc_clk) begin
        if (a_ack) a_rd_cnt <= 0;
        else if (a_rd) begin a_rd_cnt <= a_rd_cnt + 1; a_last_rd <= cyc; end
        if (b_ack) b_rd_cnt <= 0;
        else if (b_rd) begin b_rd_cnt <= b_rd_cnt + 1; b_last_rd <= cyc; end
    end
    assign a_dout = (stub_done_poll != 0 && a_rd_cnt >= stub_done_poll && cyc == a_last_rd + 3) ? 8'h01 : 8'hfe;
    assign b_dout = (stub_done_poll != 0 && b_rd_cnt >= stub_done_poll && cyc == b_last_rd + 3) ? 8'h01 : 8'hfe;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Timeline model of the main instance: k counts cycles since the acceptance cycle.
    logic       m_active = 1'b0;
    int         m_k = 0, m_kdone = 0;
    logic       m_to = 1'b0;
    logic [8:0] m_addr[13];
    logic [7:0] m_din[13];

    always @(negedge nfc_clk) begin
        logic [22:0] exp_v, act_v;
        logic e_ack, e_busy, e_done, e_to, e_wr, e_rd;
        logic [8:0] e_addr;
        logic [7:0] e_din;
        int pd;
        {e_ack, e_busy, e_done, e_to, e_wr, e_rd, e_addr, e_din} = '0;
        if (!rstb_nfc) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (seq_req) begin e_ack = 1'b1; e_busy = 1'b1; end
        end else if (m_k == m_kdone) begin
            e_done = 1'b1;
            e_to   = m_to;
        end else begin
            e_busy = 1'b1;
            if (m_k <= KICK_K && (m_k % 2) == 1) begin
                e_wr   = 1'b1;
                e_addr = m_addr[(m_k - 1) / 2];
                e_din  = m_din[(m_k - 1) / 2];
            end else if (m_k >= FIRST_RD_K && ((m_k - FIRST_RD_K) % PERIOD_A) == 0) begin
                e_rd   = 1'b1;
                e_addr = NFC_IF_STATUS_OFFSET;
            end
        end
        exp_v = {e_ack, e_busy, e_done, e_to, e_wr, e_rd, e_addr, e_din};
        act_v = {a_ack, a_busy, a_done, a_to, a_wr, a_rd, a_addr, a_din};
        check_output("cycle_model", 32'(act_v), 32'(exp_v));

        if (rstb_nfc && !m_active && seq_req) begin
            for (int i = 0; i < 4; i++) begin
                m_addr[i]     = NFC_ROW_ADDR0_OFFSET + 9'(i);
                m_din[i]      = row[8*i +: 8];
                m_addr[4 + i] = NFC_COLUMN_ADDR0_OFFSET + 9'(i);
                m_din[4 + i]  = col[8*i +: 8];
            end
            m_addr[8]  = NFC_ADDR_CNT_OFFSET;      m_din[8]  = addr_cnt;
            m_addr[9]  = NFC_TIMING_CONFC_OFFSET;  m_din[9]  = timing;
            m_addr[10] = NFC_TRN_CNT0_OFFSET;      m_din[10] = trn[7:0];
            m_addr[11] = NFC_TRN_CNT0_OFFSET + 9'd1; m_din[11] = trn[15:8];
            m_addr[12] = NFC_IF_CTRL0_OFFSET;      m_din[12] = ctrl;
            if (stub_done_poll != 0 && stub_done_poll <= POLL_MAX_A) begin
                pd = stub_done_poll - 1; m_to = 1'b0;
            end else begin
                pd = POLL_MAX_A - 1;     m_to = 1'b1;
            end
            m_kdone  = FIRST_RD_K + pd * PERIOD_A + RD_LAT_A + 1;
            m_k      = 1;
            m_active = 1'b1;
        end else if (m_active) begin
            if (m_k == m_kdone) m_active = 1'b0;
            else m_k++;
        end
    end

    // Transaction log used by the literal checks.
    int         ack_total = 0, done_total = 0, ack_cyc = 0, wr_n = 0, rd_n = 0, done_cyc = 0;
    logic       done_seen = 1'b0, done_to = 1'b0;
    int         wr_cyc_log[16];
    logic [8:0] wr_addr_log[16];
    logic [7:0] wr_din_log[16];
    int         rd_cyc_log[8];
    int         b_rd_n = 0;
    logic       b_done_seen = 1'b0, b_done_to = 1'b0;

    always @(negedge nfc_clk) begin
        if (a_ack) begin ack_total++; ack_cyc = cyc; wr_n = 0; rd_n = 0; done_seen = 1'b0; end
        if (a_wr && wr_n < 16) begin
            wr_cyc_log[wr_n] = cyc; wr_addr_log[wr_n] = a_addr; wr_din_log[wr_n] = a_din; wr_n++;
        end
        if (a_rd) begin if (rd_n < 8) rd_cyc_log[rd_n] = cyc; rd_n++; end
        if (a_done) begin done_total++; done_seen = 1'b1; done_to = a_to; done_cyc = cyc; end
        if (b_ack) begin b_rd_n = 0; b_done_seen = 1'b0; end
        if (b_rd) b_rd_n++;
        if (b_done) begin b_done_seen = 1'b1; b_done_to = b_to; end
    end

    task automatic apply_stimulus(input logic [31:0] r, input logic [31:0] c, input logic [7:0] ac,
                                  input logic [7:0] tm, input logic [15:0] t, input logic [7:0] ct,
                                  input logic also_b);
        @(posedge nfc_clk); #1;
        row = r; col = c; addr_cnt = ac; timing = tm; trn = t; ctrl = ct;
        seq_req = 1'b1; seq_req_b = also_b;
        @(posedge nfc_clk); #1;
        seq_req = 1'b0; seq_req_b = 1'b0;
    endtask

    task automatic wait_done_a(input int budget);
        int n = 0;
        while (!done_seen && n < budget) begin @(posedge nfc_clk); n++; end
        check_output("wait_done_a", 32'(done_seen), 32'd1);
        #1;
    endtask

    task automatic wait_done_b(input int budget);
        int n = 0;
        while (!b_done_seen && n < budget) begin @(posedge nfc_clk); n++; end
        check_output("wait_done_b", 32'(b_done_seen), 32'd1);
        #1;
    endtask

    logic [8:0] lit_addr[13] = '{9'h010, 9'h011, 9'h012, 9'h013, 9'h014, 9'h015, 9'h016,
                                 9'h017, 9'h018, 9'h019, 9'h01a, 9'h01b, 9'h020};
    logic [7:0] lit_din[13]  = '{8'h00, 8'h22, 8'hcc, 8'h55, 8'h02, 8'h03, 8'haa,
                                 8'h00, 8'h1a, 8'h36, 8'h10, 8'h00, 8'hc9};

    initial begin
        int ack_base, done_base, n;
        repeat (3) @(posedge nfc_clk);
        #1;
        check_output("reset_outputs", 32'({a_ack, a_busy, a_done, a_to, a_wr, a_rd, a_addr, a_din}), 32'd0);
        rstb_nfc = 1'b1;
        repeat (2) @(posedge nfc_clk);

        $display("[TB] write list, done on 3rd poll");
        stub_done_poll = 3;
        apply_stimulus(32'h55cc2200, 32'h00aa0302, 8'h1a, 8'h36, 16'h0010, 8'hc9, 1'b0);
        wait_done_a(200);
        check_output("wr_count", 32'(wr_n), 32'd13);
        for (int i = 0; i < 13; i++) begin
            check_output($sformatf("wr%0d_addr", i), 32'(wr_addr_log[i]), 32'(lit_addr[i]));
            check_output($sformatf("wr%0d_din", i), 32'(wr_din_log[i]), 32'(lit_din[i]));
        end
        check_output("kick_offset", 32'(wr_cyc_log[12] - ack_cyc), 32'd25);
        check_output("rd_count_3", 32'(rd_n), 32'd3);
        for (int i = 1; i < 3; i++)
            check_output("rd_spacing", 32'(rd_cyc_log[i] - rd_cyc_log[i-1]), 32'd12);
        check_output("done_offset_3", 32'(done_cyc - ack_cyc), 32'd55);
        check_output("timeout_0", 32'(done_to), 32'd0);

        $display("[TB] status never done");
        stub_done_poll = 0;
        apply_stimulus(32'h01020304, 32'h0a0b0c0d, 8'h05, 8'h77, 16'hbeef, 8'h81, 1'b0);
        wait_done_a(200);
        check_output("rd_count_to", 32'(rd_n), 32'd4);
        check_output("timeout_1", 32'(done_to), 32'd1);
        check_output("done_offset_to", 32'(done_cyc - ack_cyc), 32'd67);

        $display("[TB] request held high");
        stub_done_poll = 1;
        ack_base = ack_total;
        @(posedge nfc_clk); #1;
        seq_req = 1'b1;
        @(posedge nfc_clk);
        wait_done_a(200);
        check_output("held_single_ack", 32'(ack_total - ack_base), 32'd1);
        check_output("second_ack_after_done", 32'(a_ack), 32'd1);
        @(posedge nfc_clk); #1;
        seq_req = 1'b0;
        wait_done_a(200);
        check_output("held_second_done_to", 32'(done_to), 32'd0);

        $display("[TB] reset during write index 5");
        apply_stimulus(32'h55cc2200, 32'h00aa0302, 8'h1a, 8'h36, 16'h0010, 8'hc9, 1'b0);
        n = 0;
        while (!(a_wr && a_addr == 9'h015) && n < 40) begin @(negedge nfc_clk); n++; end
        check_output("reach_index5", 32'(a_wr && a_addr == 9'h015), 32'd1);
        done_base = done_total;
        #1 rstb_nfc = 1'b0;
        #1 check_output("abort_outputs", 32'({a_ack, a_busy, a_done, a_to, a_wr, a_rd, a_addr, a_din}), 32'd0);
        repeat (2) @(posedge nfc_clk);
        #1 rstb_nfc = 1'b1;
        repeat (80) @(posedge nfc_clk);
        check_output("no_done_after_abort", 32'(done_total - done_base), 32'd0);
        apply_stimulus(32'h55cc2200, 32'h00aa0302, 8'h1a, 8'h36, 16'h0010, 8'hc9, 1'b0);
        wait_done_a(200);
        check_output("restart_first_addr", 32'(wr_addr_log[0]), 32'h010);
        check_output("restart_wr_count", 32'(wr_n), 32'd13);

        $display("[TB] read latency 3 vs 1");
        stub_done_poll = 1;
        apply_stimulus(32'hdeadbeef, 32'h12345678, 8'h04, 8'h11, 16'h0800, 8'h5a, 1'b1);
        wait_done_a(200);
        check_output("lat3_detected", 32'(done_to), 32'd0);
        check_output("lat3_rd_count", 32'(rd_n), 32'd1);
        wait_done_b(200);
        check_output("lat1_timeout", 32'(b_done_to), 32'd1);
        check_output("lat1_rd_count", 32'(b_rd_n), 32'd4);

        repeat (3) @(posedge nfc_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
